// File: rtl/reg_slave_if.sv
// reg_env command bus: cmd/addr/write data from master, read data back.
// Modports: master drives cmd side, slave returns cmd_data_m2s.
interface reg_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data_s2m;
  logic [DATA_W-1:0] cmd_data_m2s;

  modport master (
    output cmd, cmd_addr, cmd_data_s2m,
    input  cmd_data_m2s
  );

  modport slave (
    input  cmd, cmd_addr, cmd_data_s2m,
    output cmd_data_m2s
  );
endinterface

// File: rtl/reg_slave.sv
// Register slave: per-channel CTRL (RW) and STAT (RO) regs on reg_env bus.
// Ports: clk, rstn (async low), bus (slave modport), slv_en/prio/len
// outputs, fifo_avail_i status. Optional ERR reg at 0x20: `REG_ERR_EN.
module reg_slave #(
  parameter int CH_NUM  = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int AVAIL_W = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  reg_slave_if.slave                bus,
  output logic [CH_NUM-1:0]         slv_en_o,
  output logic [2*CH_NUM-1:0]       slv_prio_o,
  output logic [3*CH_NUM-1:0]       slv_len_o,
  input  logic [AVAIL_W*CH_NUM-1:0] fifo_avail_i
);

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSV   = 2'b11
  } cmd_e;

  localparam int WA_W = ADDR_W - 2;

  cmd_e            cmd;
  logic [WA_W-1:0] word;
  logic            is_rd;
  logic            is_wr;

  assign cmd   = cmd_e'(bus.cmd);
  assign word  = bus.cmd_addr[ADDR_W-1:2];

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    unique case (cmd)
      CMD_READ:  is_rd = 1'b1;
      CMD_WRITE: is_wr = 1'b1;
      default:   ;
    endcase
  end

  logic [CH_NUM-1:0] ctrl_sel;
  logic [CH_NUM-1:0] stat_sel;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      ctrl_sel[i] = (word == WA_W'(i));
      stat_sel[i] = (word == WA_W'(4 + i));
    end
  end

  logic [5:0]        ctrl_q [CH_NUM];
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // Only the low 6 data bits are stored; address bits [1:0] never decode.
  logic unused_bits;
  assign unused_bits = ^{bus.cmd_addr[1:0], bus.cmd_data_s2m[DATA_W-1:6]};

`ifdef REG_ERR_EN
  logic        err_sel;
  logic        mapped;
  logic        illegal;
  logic [15:0] err_cnt;
  logic        err_flag;

  assign err_sel = (word == WA_W'(8));
  assign mapped  = (|ctrl_sel) | (|stat_sel) | err_sel;
  assign illegal = (cmd == CMD_RSV)
                 | ((is_rd | is_wr) & ~mapped)
                 | (is_wr & (|stat_sel));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (is_wr && err_sel) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (illegal) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ctrl_sel[i])
        rd_d[5:0] = ctrl_q[i];
      if (stat_sel[i])
        rd_d[AVAIL_W-1:0] = fifo_avail_i[i*AVAIL_W +: AVAIL_W];
    end
`ifdef REG_ERR_EN
    if (err_sel) begin
      rd_d[DATA_W-1] = err_flag;
      rd_d[15:0]     = err_cnt;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH_NUM; i++)
        ctrl_q[i] <= 6'd1;
    end else if (is_wr) begin
      for (int i = 0; i < CH_NUM; i++)
        if (ctrl_sel[i])
          ctrl_q[i] <= bus.cmd_data_s2m[5:0];
    end
  end

  // Read data holds across IDLE/WRITE/reserved cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rd_q <= '0;
    else if (is_rd)
      rd_q <= rd_d;
  end

  assign bus.cmd_data_m2s = rd_q;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      slv_en_o[i]          = ctrl_q[i][0];
      slv_prio_o[2*i +: 2] = ctrl_q[i][2:1];
      slv_len_o[3*i +: 3]  = ctrl_q[i][5:3];
    end
  end

endmodule
